lbp_hist: RTL and testbench

- Downstream consumer of the LBP stage.
- Snoops the LBP result write port (`lbp_valid`/`lbp_addr`/`lbp_data`) and the LBP `finish` flag.
- Accumulates a 256-bin histogram of LBP codes for one 128x128 frame.
- Once `finish` is seen, streams the bins out in order over a valid/ready port. The histogram then feeds the feature-matching stage.

---
 rtl/lbp_hist.sv | 141 ++++++++++++++
 tb/tb_lbp_hist.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_hist.sv
`default_nettype none
// ============================================================================
//  Module   : lbp_hist
//  Purpose  : Snoops the LBP result write port, builds a 256-bin histogram of
//             LBP codes for one frame, then streams the bins out in ascending
//             order over a valid/ready port once the LBP stage signals finish.
//  Revision : 1.0 - initial release
// ============================================================================
module lbp_hist #(
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    input  logic             clear,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done,
    output logic [CNT_W-1:0] lbp_total,
    output logic             ovf,
    output logic [13:0]      last_addr
);

    localparam logic [1:0]       c_ST_ACCUM = 2'd0;
    localparam logic [1:0]       c_ST_DRAIN = 2'd1;
    localparam logic [1:0]       c_ST_DONE  = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_bins [256];
    logic [CNT_W-1:0] r_total;
    logic             r_ovf;
    logic [13:0]      r_last_addr;
    logic             r_hist_valid;
    logic [7:0]       r_hist_bin;
    logic [CNT_W-1:0] r_hist_count;
    logic             r_hist_done;

    logic             w_count;
    logic             w_clear;
    logic             w_bin_sat;
    logic             w_tot_sat;
    logic [7:0]       w_next_bin;

    // Pixels are counted only while accumulating; clear only acts in DONE.
    always_comb begin
        w_count    = (r_state == c_ST_ACCUM) && lbp_valid;
        w_clear    = (r_state == c_ST_DONE) && clear;
        w_bin_sat  = (r_bins[lbp_data] == c_CNT_MAX);
        w_tot_sat  = (r_total == c_CNT_MAX);
        w_next_bin = r_hist_bin + 8'd1;
    end

    // Bin counters: saturating single-cycle increment, bulk zero on clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) r_bins[i] <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < 256; i++) r_bins[i] <= '0;
        end else if (w_count && !w_bin_sat) begin
            r_bins[lbp_data] <= r_bins[lbp_data] + c_CNT_ONE;
        end
    end

    // Frame total, sticky overflow flag and last counted pixel address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total     <= '0;
            r_ovf       <= 1'b0;
            r_last_addr <= '0;
        end else if (w_clear) begin
            r_total <= '0;
            r_ovf   <= 1'b0;
        end else if (w_count) begin
            if (!w_tot_sat) r_total <= r_total + c_CNT_ONE;
            if (w_bin_sat || w_tot_sat) r_ovf <= 1'b1;
            r_last_addr <= lbp_addr;
        end
    end

    // Frame sequencer and registered drain port. The first DRAIN cycle only
    // loads bin 0, so the counter updated at the finish edge is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_ACCUM;
            r_hist_valid <= 1'b0;
            r_hist_bin   <= '0;
            r_hist_count <= '0;
            r_hist_done  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ACCUM: begin
                    if (finish) begin
                        r_state    <= c_ST_DRAIN;
                        r_hist_bin <= '0;
                    end
                end
                c_ST_DRAIN: begin
                    if (!r_hist_valid) begin
                        r_hist_valid <= 1'b1;
                        r_hist_count <= r_bins[r_hist_bin];
                    end else if (hist_ready) begin
                        if (r_hist_bin == 8'hFF) begin
                            r_hist_valid <= 1'b0;
                            r_hist_done  <= 1'b1;
                            r_state      <= c_ST_DONE;
                        end else begin
                            r_hist_bin   <= w_next_bin;
                            r_hist_count <= r_bins[w_next_bin];
                        end
                    end
                end
                c_ST_DONE: begin
                    if (clear) begin
                        r_state      <= c_ST_ACCUM;
                        r_hist_done  <= 1'b0;
                        r_hist_bin   <= '0;
                        r_hist_count <= '0;
                    end
                end
                default: r_state <= c_ST_ACCUM;
            endcase
        end
    end

    assign hist_valid = r_hist_valid;
    assign hist_bin   = r_hist_bin;
    assign hist_count = r_hist_count;
    assign hist_done  = r_hist_done;
    assign lbp_total  = r_total;
    assign ovf        = r_ovf;
    assign last_addr  = r_last_addr;

endmodule
`default_nettype wire

// File: tb/tb_lbp_hist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbp_hist
//  Purpose  : Self-checking bench for lbp_hist (default width plus a 4-bit
//             instance for saturation).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lbp_hist;

    typedef struct {
        logic [7:0] code;
        int         reps;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        logic [7:0] bin;
        int         cnt;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lbp_valid = 1'b0;
    logic [13:0] lbp_addr = '0;
    logic [7:0]  lbp_data = '0;
    logic        finish = 1'b0;
    logic        clear = 1'b0;
    logic        hist_ready = 1'b0;
    logic        hist_valid;
    logic [7:0]  hist_bin;
    logic [14:0] hist_count;
    logic        hist_done;
    logic [14:0] lbp_total;
    logic        ovf;
    logic [13:0] last_addr;

    logic        s_lbp_valid = 1'b0;
    logic [7:0]  s_lbp_data = '0;
    logic        s_finish = 1'b0;
    logic        s_hist_ready = 1'b0;
    logic        s_hist_valid;
    logic [7:0]  s_hist_bin;
    logic [3:0]  s_hist_count;
    logic        s_hist_done;
    logic [3:0]  s_lbp_total;
    logic        s_ovf;
    logic [13:0] s_last_addr;

    int    checks = 0;
    int    failures = 0;
    int    model_bins [256];
    int    model_total = 0;
    int    captured [256];
    beat_t sbq [$];
    vec_t  vecs [3];

    always #5 clk = ~clk;

    lbp_hist #(.CNT_W(15)) dut (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .clear(clear),
        .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_bin(hist_bin),
        .hist_count(hist_count), .hist_done(hist_done), .lbp_total(lbp_total),
        .ovf(ovf), .last_addr(last_addr)
    );

    lbp_hist #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .lbp_valid(s_lbp_valid), .lbp_addr(14'd0),
        .lbp_data(s_lbp_data), .finish(s_finish), .clear(1'b0),
        .hist_valid(s_hist_valid), .hist_ready(s_hist_ready), .hist_bin(s_hist_bin),
        .hist_count(s_hist_count), .hist_done(s_hist_done), .lbp_total(s_lbp_total),
        .ovf(s_ovf), .last_addr(s_last_addr)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_bins[i] = 0;
        model_total = 0;
    endtask

    // One counted pixel; consecutive calls give back-to-back valids.
    task automatic pixel(input logic [7:0] code, input logic [13:0] addr);
        lbp_valid = 1'b1;
        lbp_data  = code;
        lbp_addr  = addr;
        model_bins[code]++;
        model_total++;
        step();
        lbp_valid = 1'b0;
    endtask

    // Raise finish and drain all 256 bins against the scoreboard queue.
    task automatic drain(input bit bp, input bit junk);
        int         n = 0;
        int         cyc = 0;
        bit         pv = 1'b0;
        logic [7:0] pb = '0;
        logic [14:0] pc = '0;
        beat_t      e;
        for (int i = 0; i < 256; i++) sbq.push_back('{bin: 8'(i), cnt: model_bins[i]});
        finish = 1'b1;
        step();
        chk("drain_valid_at_T", hist_valid, 0);
        while (n < 256 && cyc < 3000) begin
            if (cyc == 1) begin
                chk("drain_valid_at_T1", hist_valid, 1);
                chk("drain_first_bin", hist_bin, 0);
            end
            if (pv) begin
                chk("hold_valid", hist_valid, 1);
                chk("hold_bin", hist_bin, pb);
                chk("hold_count", hist_count, pc);
            end
            hist_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk) begin
                lbp_valid = 1'b1;
                lbp_data  = 8'($urandom_range(0, 255));
            end
            if (hist_valid && hist_ready) begin
                e = sbq.pop_front();
                chk("beat_bin", hist_bin, e.bin);
                chk("beat_count", hist_count, e.cnt);
                captured[hist_bin] = hist_count;
                n++;
                pv = 1'b0;
            end else begin
                pv = hist_valid;
            end
            pb = hist_bin;
            pc = hist_count;
            step();
            cyc++;
        end
        lbp_valid  = 1'b0;
        hist_ready = 1'b0;
        chk("drain_beats", n, 256);
        chk("done_after_255", hist_done, 1);
        chk("valid_low_in_done", hist_valid, 0);
        chk("total_after_drain", lbp_total, model_total);
        sbq.delete();
    endtask

    task automatic do_clear();
        finish = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        chk("clear_total", lbp_total, 0);
        chk("clear_ovf", ovf, 0);
        chk("clear_done", hist_done, 0);
    endtask

    initial begin
        bit found;
        vecs[0] = '{code: 8'h00, reps: 10, exp_cnt: 10};
        vecs[1] = '{code: 8'hFF, reps: 3,  exp_cnt: 3};
        vecs[2] = '{code: 8'h5A, reps: 1,  exp_cnt: 1};
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        chk("rst_hist_valid", hist_valid, 0);
        chk("rst_hist_bin", hist_bin, 0);
        chk("rst_hist_count", hist_count, 0);
        chk("rst_hist_done", hist_done, 0);
        chk("rst_total", lbp_total, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_last_addr", last_addr, 0);
        repeat (3) step();
        chk("idle_no_valid", hist_valid, 0);

        // Known codes from the vector table
        begin
            int a = 0;
            for (int v = 0; v < 3; v++)
                for (int r = 0; r < vecs[v].reps; r++) begin
                    pixel(vecs[v].code, 14'(100 + a));
                    a++;
                end
            chk("known_total", lbp_total, 14);
            chk("known_last_addr", last_addr, 100 + a - 1);
        end
        drain(1'b0, 1'b0);
        for (int v = 0; v < 3; v++) chk("known_bin", captured[vecs[v].code], vecs[v].exp_cnt);
        chk("known_bin1_zero", captured[1], 0);

        // Clear, new frame, ignored clear in ACCUM, drain under backpressure
        do_clear();
        for (int i = 0; i < 5; i++) pixel(8'h33, 14'(i));
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_ignored_accum", lbp_total, 5);
        drain(1'b1, 1'b1);
        chk("bp_bin51", captured[51], 5);
        chk("bp_ovf", ovf, 0);

        // Full 128x128 frame, 64 of each code
        do_clear();
        for (int i = 0; i < 16384; i++) pixel(8'(i % 256), 14'(i));
        chk("full_total", lbp_total, 16384);
        chk("full_ovf", ovf, 0);
        chk("full_last_addr", last_addr, 16383);
        drain(1'b0, 1'b0);
        chk("full_bin0", captured[0], 64);
        chk("full_bin255", captured[255], 64);

        // Asynchronous reset in the middle of a drain
        do_clear();
        for (int i = 0; i < 4; i++) pixel(8'd100, 14'(i));
        finish = 1'b1;
        hist_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            if (hist_valid && hist_bin == 8'd100) found = 1'b1;
            else step();
        end
        chk("reach_bin100", found, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_hist_valid", hist_valid, 0);
        chk("arst_hist_bin", hist_bin, 0);
        chk("arst_hist_count", hist_count, 0);
        chk("arst_total", lbp_total, 0);
        chk("arst_last_addr", last_addr, 0);
        finish = 1'b0;
        hist_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step();

        // Saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            s_lbp_valid = 1'b1;
            s_lbp_data  = 8'h11;
            step();
        end
        s_lbp_valid = 1'b0;
        chk("sat_total", s_lbp_total, 15);
        chk("sat_ovf", s_ovf, 1);
        s_finish = 1'b1;
        s_hist_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (s_hist_valid && s_hist_bin == 8'd17) found = 1'b1;
            else step();
        end
        chk("sat_reach_bin17", found, 1);
        chk("sat_bin17", s_hist_count, 15);
        step();
        chk("sat_bin18", s_hist_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
